pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Drives the write-enable (xxW) and flush (xxRST) controls of the four pipeline latches
//  (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
//  Consumes hit, hazard, branch and halt status from the stages.
//  A small FSM holds the pipeline on data-cache misses, latches halt, and squashes stale
//  fetches after a redirect.
// PARAMETERS
//  REG_W   5    register-select width for load-use compare
//  CNT_W   32   perf counter width (PIPE_PERF_EN only)
// PORTS
//  CLK         in   1      clock, rising edge
//  nRST        in   1      synchronous active-low reset
//  ihit        in   1      I-cache returned instruction this cycle
//  dhit        in   1      D-cache completed MEM-stage access this cycle
//  mem_dREN    in   1      MEM stage issues a load
//  mem_dWEN    in   1      MEM stage issues a store
//  mem_brtaken in   1      branch resolved taken in MEM (PC redirect)
//  mem_halt    in   1      halt instruction in MEM
//  id_jump     in   1      J/JAL/JR decoded in ID (PC redirect)
//  ex_dREN     in   1      EX-stage instruction is a load
//  ex_rt       in   REG_W  EX-stage load destination
//  id_rs       in   REG_W  ID-stage source 1
//  id_rt       in   REG_W  ID-stage source 2
//  pcW         out  1      PC register write enable
//  ifidW, idexW, exmemW, memwbW          out 1 latch write enables
//  ifidRST, idexRST, exmemRST, memwbRST  out 1 latch flush (priority over W)
//  halt        out  1      processor halted
// BEHAVIOUR
//  Reset value (nRST=0 at edge): state=RUN, redir_pend=0.
//  - While nRST=0, all W and RST outputs are 0.
//  - halt=0.
//  - Counters are cleared.
//  States: RUN, DWAIT, HALTED. Outputs are combinational from state + inputs.
//  Priority in RUN/DWAIT, highest first: dmiss > mem_brtaken > load-use > id_jump > !ihit.
//  Default (no event): all W=1, pcW=ihit, all RST=0.
//  dmiss = (mem_dREN|mem_dWEN) & !dhit.
//    - Response: pcW=ifidW=idexW=exmemW=0; memwbRST=1 (bubble, no duplicate WB).
//    - Next state: DWAIT.
//  DWAIT:
//    - Stays in DWAIT, with the same outputs, while dmiss.
//    - On dhit, outputs are the RUN defaults for that cycle; next state RUN.
//  mem_brtaken (no dmiss):
//    - Outputs: pcW=1; ifidRST=idexRST=exmemRST=1; memwbW=1.
//    - If !ihit, set redir_pend.
//  load-use = ex_dREN & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
//    - Outputs: pcW=0, ifidW=0, idexRST=1; exmem/memwb advance.
//  id_jump:
//    - Outputs: pcW=1, ifidRST=1, rest advance.
//    - If !ihit, set redir_pend.
//  !ihit alone:
//    - Outputs: pcW=0, ifidRST=1 (bubble into ID), rest advance.
//  redir_pend: the next ihit carries a stale instruction.
//    - That cycle: ifidRST=1, pcW=0.
//    - Clear redir_pend.
//    - A newer redirect in the same cycle re-sets redir_pend (set wins).
//  mem_halt (no dmiss):
//    - memwbW=1.
//    - exmemRST=idexRST=ifidRST=1, pcW=0.
//    - Next state: HALTED.
//  HALTED:
//    - All W=0, RST=0, pcW=0, halt=1.
//    - Leaves only on reset.
//  Reset mid-miss: returns to RUN and drops redir_pend; any dhit arriving later is ignored.
// CONFIGURATION
//  PIPE_PERF_EN defined: extra outputs stall_cnt and flush_cnt, both CNT_W wide.
//    - stall_cnt += 1 every cycle pcW=0 in RUN/DWAIT.
//    - flush_cnt += 1 every mem_brtaken or id_jump.
//    - Both saturate at all-ones and clear on reset.
//  PIPE_PERF_EN undefined: no counter ports or logic.
// TESTING
//  1. Reset, ihit=1, no events -> every W=1, all RST=0, pcW=1, halt=0.
//  2. mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 ->
//     - miss cycles: 3 cycles pcW=ifidW=idexW=exmemW=0, memwbRST=1, state DWAIT;
//     - dhit cycle: defaults, state RUN.
//  3. ex_dREN=1, ex_rt=5, id_rs=5 -> pcW=0, ifidW=0, idexRST=1, exmemW=memwbW=1.
//     Same with ex_rt=0 -> no stall.
//  4. mem_brtaken=1 with ihit=0, next cycle ihit=1 ->
//     - cycle 1: flush IF/ID, ID/EX, EX/MEM;
//     - cycle 2: ifidRST=1, pcW=0;
//     - cycle 3 with ihit=1: normal.
//  5. mem_brtaken=1 and dmiss same cycle -> dmiss response only, no flush until dhit.
//  6. mem_halt=1 -> memwbW=1, halt=1 next cycle.
//     Toggle all inputs for 10 cycles -> outputs frozen; nRST=0 -> halt=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline latch write-enable / flush controller with D-miss hold, halt latch and redirect squash.
// Optional PIPE_PERF_EN adds saturating stall_cnt / flush_cnt performance counters.
module pipeline_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_brtaken,
    input  logic             mem_halt,
    input  logic             id_jump,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             pcW,
    output logic             ifidW,
    output logic             idexW,
    output logic             exmemW,
    output logic             memwbW,
    output logic             ifidRST,
    output logic             idexRST,
    output logic             exmemRST,
    output logic             memwbRST,
    output logic             halt
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state, state_next;
    logic   redir_pend, redir_next;
    logic   dmiss;
    logic   load_use;
    logic   redirect;

    if (CNT_W < 1 || REG_W < 1) begin : g_param_chk
        $error("pipeline_ctrl: REG_W and CNT_W must be at least 1");
    end

    assign dmiss    = (mem_dREN | mem_dWEN) & ~dhit;
    assign load_use = ex_dREN & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
    // A redirect only takes effect when it wins priority this cycle.
    assign redirect = ~dmiss & ~mem_halt & (mem_brtaken | (~load_use & id_jump));

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= RUN;
            redir_pend <= 1'b0;
        end else begin
            state      <= state_next;
            redir_pend <= redir_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        redir_next = redir_pend;
        case (state)
            RUN, DWAIT: begin
                if (dmiss) begin
                    state_next = DWAIT;
                end else begin
                    state_next = mem_halt ? HALTED : RUN;
                    if (ihit) begin
                        redir_next = 1'b0;
                    end
                    if (redirect && !ihit) begin
                        redir_next = 1'b1;
                    end
                end
            end
            HALTED: state_next = HALTED;
            default: begin
                state_next = RUN;
                redir_next = 1'b0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        pcW      = 1'b0;
        ifidW    = 1'b0;
        idexW    = 1'b0;
        exmemW   = 1'b0;
        memwbW   = 1'b0;
        ifidRST  = 1'b0;
        idexRST  = 1'b0;
        exmemRST = 1'b0;
        memwbRST = 1'b0;
        halt     = 1'b0;
        if (!nRST) begin
            pcW = 1'b0;
        end else if (state == HALTED) begin
            halt = 1'b1;
        end else begin
            pcW    = ihit;
            ifidW  = 1'b1;
            idexW  = 1'b1;
            exmemW = 1'b1;
            memwbW = 1'b1;
            if (dmiss) begin
                pcW      = 1'b0;
                ifidW    = 1'b0;
                idexW    = 1'b0;
                exmemW   = 1'b0;
                memwbRST = 1'b1;
            end else if (mem_halt) begin
                pcW      = 1'b0;
                ifidRST  = 1'b1;
                idexRST  = 1'b1;
                exmemRST = 1'b1;
            end else if (mem_brtaken) begin
                pcW      = 1'b1;
                ifidRST  = 1'b1;
                idexRST  = 1'b1;
                exmemRST = 1'b1;
            end else if (load_use) begin
                pcW     = 1'b0;
                ifidW   = 1'b0;
                idexRST = 1'b1;
            end else if (id_jump) begin
                pcW     = 1'b1;
                ifidRST = 1'b1;
            end else if (!ihit) begin
                pcW     = 1'b0;
                ifidRST = 1'b1;
            end else if (redir_pend) begin
                // Fetch returning now belongs to the pre-redirect path.
                pcW     = 1'b0;
                ifidRST = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = nRST & (state != HALTED) & ~pcW;
    assign flush_evt = nRST & (state != HALTED) & (mem_brtaken | id_jump);

    // Saturating performance counters
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues hand-computed output vectors, monitor compares.
module tb_pipeline_ctrl;

    localparam int unsigned REG_W = 5;

    // Input flag masks: {nRST, ihit, dhit, mem_dREN, mem_dWEN, mem_brtaken, mem_halt, id_jump, ex_dREN}
    localparam logic [8:0] F_N   = 9'h100;
    localparam logic [8:0] F_I   = 9'h080;
    localparam logic [8:0] F_DH  = 9'h040;
    localparam logic [8:0] F_DR  = 9'h020;
    localparam logic [8:0] F_DW  = 9'h010;
    localparam logic [8:0] F_BR  = 9'h008;
    localparam logic [8:0] F_MH  = 9'h004;
    localparam logic [8:0] F_J   = 9'h002;
    localparam logic [8:0] F_EXR = 9'h001;

    // Output vectors: {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, memwbRST, halt}
    localparam logic [9:0] O_ZERO  = 10'b0000000000;
    localparam logic [9:0] O_DEF   = 10'b1111100000;
    localparam logic [9:0] O_MISS  = 10'b0000100010;
    localparam logic [9:0] O_LU    = 10'b0011101000;
    localparam logic [9:0] O_BR    = 10'b1111111100;
    localparam logic [9:0] O_STALE = 10'b0111110000;
    localparam logic [9:0] O_NOI   = 10'b0111110000;
    localparam logic [9:0] O_JUMP  = 10'b1111110000;
    localparam logic [9:0] O_HALTI = 10'b0111111100;
    localparam logic [9:0] O_HALTD = 10'b0000000001;

    typedef struct {
        logic [9:0] outs;
        string      name;
    } exp_t;

    logic             CLK;
    logic             nRST;
    logic             ihit, dhit, mem_dREN, mem_dWEN, mem_brtaken, mem_halt, id_jump, ex_dREN;
    logic [REG_W-1:0] ex_rt, id_rs, id_rt;
    logic             pcW, ifidW, idexW, exmemW, memwbW;
    logic             ifidRST, idexRST, exmemRST, memwbRST, halt;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    pipeline_ctrl #(.REG_W(REG_W), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_brtaken(mem_brtaken),
        .mem_halt(mem_halt), .id_jump(id_jump), .ex_dREN(ex_dREN),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
        .pcW(pcW), .ifidW(ifidW), .idexW(idexW), .exmemW(exmemW), .memwbW(memwbW),
        .ifidRST(ifidRST), .idexRST(idexRST), .exmemRST(exmemRST), .memwbRST(memwbRST),
        .halt(halt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive one cycle of inputs just after the rising edge and queue the expected response.
    task automatic step(input logic [8:0] f, input logic [REG_W-1:0] ert, input logic [REG_W-1:0] rs,
                        input logic [REG_W-1:0] rt, input logic [9:0] outs, input string nm);
        exp_t e;
        @(posedge CLK);
        #1;
        {nRST, ihit, dhit, mem_dREN, mem_dWEN, mem_brtaken, mem_halt, id_jump, ex_dREN} = f;
        ex_rt = ert;
        id_rs = rs;
        id_rt = rt;
        e.outs = outs;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic run(input logic [8:0] f, input logic [9:0] outs, input string nm);
        step(f, 5'd0, 5'd1, 5'd2, outs, nm);
    endtask

    // Monitor: compare on the falling edge, half a cycle after inputs settle.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [9:0] got;
            e   = exp_q.pop_front();
            got = {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST, memwbRST, halt};
            checks = checks + 1;
            if (got !== e.outs) begin
                errors = errors + 1;
                $display("FAIL %s: got %b expected %b", e.name, got, e.outs);
            end
        end
    end

    initial begin
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        mem_brtaken = 1'b0; mem_halt = 1'b0; id_jump = 1'b0; ex_dREN = 1'b0;
        ex_rt = '0; id_rs = '0; id_rt = '0;

        run(F_I, O_ZERO, "reset_a");
        run(F_I, O_ZERO, "reset_b");
        run(F_N | F_I, O_DEF, "run_default");
        run(F_N, O_NOI, "no_ihit");

        run(F_N | F_I | F_DR, O_MISS, "load_miss1");
        run(F_N | F_I | F_DR, O_MISS, "load_miss2");
        run(F_N | F_I | F_DR, O_MISS, "load_miss3");
        run(F_N | F_I | F_DR | F_DH, O_DEF, "load_dhit");
        run(F_N | F_I, O_DEF, "after_miss_run");
        run(F_N | F_I | F_DW, O_MISS, "store_miss");
        run(F_N | F_I | F_DW | F_DH, O_DEF, "store_dhit");

        step(F_N | F_I | F_EXR, 5'd5, 5'd5, 5'd3, O_LU, "lu_rs");
        step(F_N | F_I | F_EXR, 5'd5, 5'd3, 5'd5, O_LU, "lu_rt");
        step(F_N | F_I | F_EXR, 5'd0, 5'd0, 5'd0, O_DEF, "lu_r0");
        step(F_N | F_I | F_EXR, 5'd5, 5'd3, 5'd4, O_DEF, "lu_nomatch");
        step(F_N | F_I, 5'd5, 5'd5, 5'd5, O_DEF, "lu_not_load");

        run(F_N | F_BR, O_BR, "br_noihit");
        run(F_N | F_I, O_STALE, "br_stale");
        run(F_N | F_I, O_DEF, "br_recovered");
        run(F_N | F_I | F_J, O_JUMP, "jump_ihit");
        run(F_N | F_I, O_DEF, "jump_no_pend");
        run(F_N | F_J, O_JUMP, "jump_noihit");
        run(F_N, O_NOI, "jump_wait");
        run(F_N | F_I, O_STALE, "jump_stale");
        run(F_N | F_I, O_DEF, "jump_recovered");
        step(F_N | F_I | F_EXR | F_J, 5'd7, 5'd7, 5'd1, O_LU, "lu_over_jump");
        step(F_N | F_I | F_EXR | F_BR, 5'd7, 5'd7, 5'd1, O_BR, "br_over_lu");

        run(F_N | F_I | F_DR | F_BR, O_MISS, "br_miss1");
        run(F_N | F_I | F_DR | F_BR, O_MISS, "br_miss2");
        run(F_N | F_I | F_DR | F_DH | F_BR, O_BR, "br_at_dhit");
        run(F_N | F_I, O_DEF, "br_miss_done");

        run(F_N | F_I | F_DR, O_MISS, "rst_mid_miss");
        run(F_I | F_DR, O_ZERO, "rst_in_miss");
        run(F_N | F_I | F_DH, O_DEF, "late_dhit_ignored");

        run(F_N | F_I | F_MH, O_HALTI, "halt_in_mem");
        for (int i = 0; i < 10; i++) begin
            step(F_N | 9'($urandom_range(0, 255)), 5'($urandom), 5'($urandom), 5'($urandom),
                 O_HALTD, "halted_frozen");
        end
        run(F_I, O_ZERO, "halt_reset");
        run(F_N | F_I, O_DEF, "halt_cleared");

        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then report.
    initial begin
        int budget;
        wait (stim_done);
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge CLK);
            budget = budget + 1;
        end
        if (exp_q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
